// File: rtl/obstacle_spawner_if.sv
// Object bus between the obstacle spawner and the hit detector / renderer.
// The spawner drives the object positions, visibility flags and the frame tick.
// The hit detector returns one-cycle CoinEn/PoliceEn pulses when the car strikes an object.
interface obstacle_spawner_if;
  logic [7:0] x_po;
  logic [6:0] y_po;
  logic [7:0] x_coin;
  logic [6:0] y_coin;
  logic       po_active;
  logic       coin_active;
  logic       FrameTick;
  logic       CoinEn;
  logic       PoliceEn;

  modport master (
    output x_po, y_po, x_coin, y_coin, po_active, coin_active, FrameTick,
    input  CoinEn, PoliceEn
  );

  modport slave (
    input  x_po, y_po, x_coin, y_coin, po_active, coin_active, FrameTick,
    output CoinEn, PoliceEn
  );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: drops a police car and a coin down the road, one row per frame tick.
// An object retires when it is hit or when it reaches the bottom row.
// After a fixed number of ticks it respawns at the top in a pseudo-random lane.
// The frame tick only runs while the game is in RUN, so pausing freezes all motion.
module obstacle_spawner #(
  parameter int unsigned TICK_DIV      = 833333,
  parameter int unsigned Y_TOP         = 0,
  parameter int unsigned Y_BOTTOM      = 119,
  parameter int unsigned HIT_ROW       = 70,
  parameter int unsigned PO_X_RANGE    = 140,
  parameter int unsigned COIN_X_RANGE  = 152,
  parameter int unsigned RESPAWN_TICKS = 30,
  parameter int unsigned COIN_OFFSET   = 45,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               CLOCK_50,
  input  logic [0:0]         KEY,
  input  logic               EnterEn,
  input  logic               PauseEn,
  obstacle_spawner_if.master bus
);

  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WAIT_MAX = RESPAWN_TICKS + COIN_OFFSET;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_PO      = WAIT_W'(RESPAWN_TICKS);
  localparam logic [WAIT_W-1:0] WAIT_COIN    = WAIT_W'(WAIT_MAX);
  localparam logic [6:0]        Y_TOP_V      = 7'(Y_TOP);
  localparam logic [6:0]        Y_BOTTOM_V   = 7'(Y_BOTTOM);
  localparam logic [7:0]        PO_RANGE_V   = 8'(PO_X_RANGE);
  localparam logic [7:0]        COIN_RANGE_V = 8'(COIN_X_RANGE);

  // Parameter sanity: rows must be ordered and lane ranges must allow a single wrap subtraction.
  if (!(Y_TOP < HIT_ROW && HIT_ROW < Y_BOTTOM && Y_BOTTOM < 128)) begin : g_bad_rows
    $error("obstacle_spawner: row parameters out of order or too large");
  end
  if (PO_X_RANGE < 128 || PO_X_RANGE > 255 || COIN_X_RANGE < 128 || COIN_X_RANGE > 255) begin : g_bad_range
    $error("obstacle_spawner: lane ranges must lie in 128..255");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("obstacle_spawner: TICK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_PAUSE} top_state_t;
  typedef enum logic {OBJ_WAIT, OBJ_FALL} obj_state_t;

  top_state_t        top_q, top_d;
  logic              start;
  logic [CNT_W-1:0]  tick_cnt;
  logic              frame_tick;
  logic [15:0]       lfsr;
  logic [1:0]        hit;

  // Index 0 is the police car, index 1 is the coin.
  obj_state_t        obj_q  [2];
  obj_state_t        obj_d  [2];
  logic [WAIT_W-1:0] wait_q [2];
  logic [WAIT_W-1:0] wait_d [2];
  logic [6:0]        y_q    [2];
  logic [6:0]        y_d    [2];
  logic [7:0]        x_q    [2];
  logic [7:0]        x_d    [2];
  logic              act_q  [2];
  logic              act_d  [2];

  assign hit = {bus.CoinEn, bus.PoliceEn};

  // Fold an 8-bit random value into a lane; one subtraction suffices because range >= 128.
  function automatic logic [7:0] wrap_x(input logic [7:0] c, input logic [7:0] r);
    return (c >= r) ? c - r : c;
  endfunction

  // Game state register.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) top_q <= TOP_IDLE;
    else         top_q <= top_d;
  end

  // Game state transitions; start marks the single IDLE->RUN edge that arms the spawn delays.
  always_comb begin
    top_d = top_q;
    start = 1'b0;
    case (top_q)
      TOP_IDLE: begin
        if (EnterEn) begin
          top_d = TOP_RUN;
          start = 1'b1;
        end
      end
      TOP_RUN:   if (PauseEn)  top_d = TOP_PAUSE;
      TOP_PAUSE: if (!PauseEn) top_d = TOP_RUN;
      default:   top_d = TOP_IDLE;
    endcase
  end

  // Frame divider: advances only in RUN and holds its count while paused.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      tick_cnt   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (top_q == TOP_RUN) begin
        if (tick_cnt == CNT_LAST) begin
          tick_cnt   <= '0;
          frame_tick <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  // Galois LFSR (x^16+x^14+x^13+x^11), free-running in every state so spawn lanes vary with timing.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) lfsr <= LFSR_SEED;
    else         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Object state registers for both falling objects.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      for (int i = 0; i < 2; i++) begin
        obj_q[i]  <= OBJ_WAIT;
        wait_q[i] <= '0;
        y_q[i]    <= Y_TOP_V;
        x_q[i]    <= 8'd0;
        act_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        obj_q[i]  <= obj_d[i];
        wait_q[i] <= wait_d[i];
        y_q[i]    <= y_d[i];
        x_q[i]    <= x_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  // Object behaviour: a hit beats a simultaneous frame tick, and x keeps its last lane on retire.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      obj_d[i]  = obj_q[i];
      wait_d[i] = wait_q[i];
      y_d[i]    = y_q[i];
      x_d[i]    = x_q[i];
      act_d[i]  = act_q[i];
      if (start) begin
        wait_d[i] = (i == 0) ? WAIT_PO : WAIT_COIN;
      end else begin
        case (obj_q[i])
          OBJ_WAIT: begin
            if (frame_tick) begin
              if (wait_q[i] == '0) begin
                obj_d[i] = OBJ_FALL;
                act_d[i] = 1'b1;
                y_d[i]   = Y_TOP_V;
                x_d[i]   = (i == 0) ? wrap_x(lfsr[7:0], PO_RANGE_V)
                                    : wrap_x(lfsr[15:8], COIN_RANGE_V);
              end else begin
                wait_d[i] = wait_q[i] - 1'b1;
              end
            end
          end
          OBJ_FALL: begin
            if (hit[i] && top_q == TOP_RUN) begin
              obj_d[i]  = OBJ_WAIT;
              act_d[i]  = 1'b0;
              y_d[i]    = Y_TOP_V;
              wait_d[i] = WAIT_PO;
            end else if (frame_tick) begin
              if (y_q[i] == Y_BOTTOM_V) begin
                obj_d[i]  = OBJ_WAIT;
                act_d[i]  = 1'b0;
                y_d[i]    = Y_TOP_V;
                wait_d[i] = WAIT_PO;
              end else begin
                y_d[i] = y_q[i] + 7'd1;
              end
            end
          end
          default: obj_d[i] = OBJ_WAIT;
        endcase
      end
    end
  end

  assign bus.x_po        = x_q[0];
  assign bus.y_po        = y_q[0];
  assign bus.po_active   = act_q[0];
  assign bus.x_coin      = x_q[1];
  assign bus.y_coin      = y_q[1];
  assign bus.coin_active = act_q[1];
  assign bus.FrameTick   = frame_tick;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with a short frame divider and short respawn delays.
// Expected spawn lanes come from an independent LFSR reference model that runs in step with the DUT.
module tb_obstacle_spawner;

  logic       CLOCK_50 = 1'b0;
  logic [0:0] KEY = 1'b1;
  logic       EnterEn;
  logic       PauseEn;

  obstacle_spawner_if bus();

  obstacle_spawner #(
    .TICK_DIV(4), .RESPAWN_TICKS(2), .COIN_OFFSET(1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .KEY(KEY),
    .EnterEn(EnterEn),
    .PauseEn(PauseEn),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  logic [7:0]  x_exp_po;
  logic [7:0]  x_exp_coin;
  int          n;
  bit          flag_a;
  bit          flag_b;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference Galois LFSR; m_prev is the value the DUT used at the most recent edge.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10));
    return r;
  endfunction

  always @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  function automatic logic [7:0] exp_lane(input logic [7:0] c, input int rng);
    int v;
    v = int'(c);
    if (v >= rng) v = v - rng;
    return 8'(v);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Stops on the negedge where FrameTick is high, before objects react to it.
  task automatic wait_ft(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 40) begin
      @(negedge CLOCK_50);
      cycles++;
      if (bus.FrameTick) seen = 1'b1;
    end
    check_output("tick_seen", seen, 1);
  endtask

  // Advances past one frame tick and returns negedges elapsed since the call.
  task automatic next_tick(output int cycles);
    wait_ft(cycles);
    @(negedge CLOCK_50);
    cycles++;
  endtask

  initial begin
    EnterEn      = 1'b0;
    PauseEn      = 1'b0;
    bus.CoinEn   = 1'b0;
    bus.PoliceEn = 1'b0;

    // Reset values appear without a clock edge.
    #5 KEY = 1'b0;
    #1;
    check_output("rst_y_po", bus.y_po, 0);
    check_output("rst_y_coin", bus.y_coin, 0);
    check_output("rst_x_po", bus.x_po, 0);
    check_output("rst_po_active", bus.po_active, 0);
    check_output("rst_coin_active", bus.coin_active, 0);
    check_output("rst_frametick", bus.FrameTick, 0);
    repeat (3) @(negedge CLOCK_50);
    KEY = 1'b1;

    // Idle without EnterEn: nothing moves, no ticks.
    flag_a = 1'b0;
    flag_b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (bus.FrameTick) flag_a = 1'b1;
      if (bus.y_po != 7'd0 || bus.y_coin != 7'd0 || bus.po_active || bus.coin_active) flag_b = 1'b1;
    end
    check_output("idle_no_tick", flag_a, 0);
    check_output("idle_quiet", flag_b, 0);

    // Start: police spawns on tick 3, coin on tick 4.
    $display("[TB] start game");
    EnterEn = 1'b1;
    @(negedge CLOCK_50);
    EnterEn = 1'b0;
    next_tick(n);
    check_output("first_tick_latency", n, 5);
    check_output("t1_po_active", bus.po_active, 0);
    next_tick(n);
    check_output("tick_period", n, 4);
    check_output("t2_po_active", bus.po_active, 0);
    next_tick(n);
    x_exp_po = exp_lane(m_prev[7:0], 140);
    check_output("t3_po_active", bus.po_active, 1);
    check_output("t3_y_po", bus.y_po, 0);
    check_output("t3_x_po", bus.x_po, x_exp_po);
    check_output("t3_x_po_range", bus.x_po < 8'd140, 1);
    check_output("t3_coin_active", bus.coin_active, 0);
    next_tick(n);
    x_exp_coin = exp_lane(m_prev[15:8], 152);
    check_output("t4_y_po", bus.y_po, 1);
    check_output("t4_coin_active", bus.coin_active, 1);
    check_output("t4_y_coin", bus.y_coin, 0);
    check_output("t4_x_coin", bus.x_coin, x_exp_coin);

    // Police falls to the bottom row one step per tick, then retires.
    for (int k = 2; k <= 119; k++) begin
      next_tick(n);
      check_output("fall_y_po", bus.y_po, k);
    end
    check_output("fall_y_coin", bus.y_coin, 118);
    next_tick(n);
    check_output("bottom_y_po", bus.y_po, 0);
    check_output("bottom_po_active", bus.po_active, 0);
    check_output("bottom_x_po_hold", bus.x_po, x_exp_po);
    check_output("bottom_y_coin", bus.y_coin, 119);
    next_tick(n);
    check_output("respawn1_po_active", bus.po_active, 0);
    check_output("coin_retire_active", bus.coin_active, 0);
    next_tick(n);
    check_output("respawn2_po_active", bus.po_active, 0);
    next_tick(n);
    x_exp_po = exp_lane(m_prev[7:0], 140);
    check_output("respawn3_po_active", bus.po_active, 1);
    check_output("respawn3_y_po", bus.y_po, 0);
    check_output("respawn3_x_po", bus.x_po, x_exp_po);

    // Fall to the hit row; coin respawns on the first of these ticks.
    for (int k = 1; k <= 70; k++) begin
      next_tick(n);
      if (k == 1) begin
        x_exp_coin = exp_lane(m_prev[15:8], 152);
        check_output("coin_respawn_active", bus.coin_active, 1);
        check_output("coin_respawn_x", bus.x_coin, x_exp_coin);
      end
    end
    check_output("hitrow_y_po", bus.y_po, 70);

    // Police hit coincident with a frame tick: the hit wins, no step to 71.
    wait_ft(n);
    check_output("hit_tick_y_po", bus.y_po, 70);
    bus.PoliceEn = 1'b1;
    @(negedge CLOCK_50);
    bus.PoliceEn = 1'b0;
    check_output("hit_po_active", bus.po_active, 0);
    check_output("hit_y_po", bus.y_po, 0);
    check_output("hit_x_po_hold", bus.x_po, x_exp_po);
    check_output("hit_y_coin", bus.y_coin, 70);
    check_output("hit_coin_active", bus.coin_active, 1);

    // Pause mid-fall; hit pulses during pause are ignored.
    PauseEn = 1'b1;
    flag_a  = 1'b0;
    flag_b  = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge CLOCK_50);
      if (bus.FrameTick) flag_a = 1'b1;
      if (bus.y_coin != 7'd70 || !bus.coin_active) flag_b = 1'b1;
      if (i == 5) bus.CoinEn = 1'b1;
      if (i == 6) bus.CoinEn = 1'b0;
      if (i == 8) bus.PoliceEn = 1'b1;
      if (i == 9) bus.PoliceEn = 1'b0;
    end
    PauseEn = 1'b0;
    check_output("pause_no_tick", flag_a, 0);
    check_output("pause_coin_frozen", flag_b, 0);
    check_output("pause_po_active", bus.po_active, 0);
    next_tick(n);
    check_output("resume_tick_latency", n, 4);
    check_output("resume_y_coin", bus.y_coin, 71);

    // Coin hit off-tick, then a stray EnterEn and a CoinEn while the coin is waiting.
    bus.CoinEn = 1'b1;
    @(negedge CLOCK_50);
    check_output("coinhit_frametick", bus.FrameTick, 0);
    check_output("coinhit_active", bus.coin_active, 0);
    check_output("coinhit_y_coin", bus.y_coin, 0);
    check_output("coinhit_x_hold", bus.x_coin, x_exp_coin);
    EnterEn = 1'b1;
    @(negedge CLOCK_50);
    bus.CoinEn = 1'b0;
    EnterEn    = 1'b0;
    check_output("coinwait_ignored", bus.coin_active, 0);
    next_tick(n);
    check_output("late_po_wait", bus.po_active, 0);
    next_tick(n);
    x_exp_po = exp_lane(m_prev[7:0], 140);
    check_output("late_po_spawn", bus.po_active, 1);
    check_output("late_x_po", bus.x_po, x_exp_po);
    check_output("late_coin_wait", bus.coin_active, 0);
    next_tick(n);
    check_output("late_y_po", bus.y_po, 1);
    check_output("late_coin_spawn", bus.coin_active, 1);
    check_output("late_y_coin", bus.y_coin, 0);

    // Asynchronous reset between clock edges mid-fall.
    #3 KEY = 1'b0;
    #1;
    check_output("arst_y_po", bus.y_po, 0);
    check_output("arst_po_active", bus.po_active, 0);
    check_output("arst_coin_active", bus.coin_active, 0);
    check_output("arst_x_po", bus.x_po, 0);
    check_output("arst_x_coin", bus.x_coin, 0);
    @(negedge CLOCK_50);
    KEY    = 1'b1;
    flag_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLOCK_50);
      if (bus.FrameTick || bus.po_active) flag_a = 1'b1;
    end
    check_output("post_reset_idle", flag_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
